out_ctrl_sc_acc: RTL and testbench

OUT_CTRL_SC_ACC -- requirements
Module: out_ctrl_sc_acc

---
 rtl/out_ctrl_sc_acc_pkg.sv | 27 ++
 rtl/out_lane_acc.sv | 33 +++
 rtl/out_ctrl_sc_acc.sv | 108 ++++++++++
 tb/tb_out_ctrl_sc_acc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_ctrl_sc_acc_pkg.sv
// Shared constants and types for the stochastic-to-binary output converter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents: default sample width and lane count, window length and counter
// widths derived from them, and the two-state controller enum.
package out_ctrl_sc_acc_pkg;

  localparam int unsigned N_DEF     = 8;
  localparam int unsigned LANES_DEF = 4;

  // Window length is a quarter of the binary range: L = 2^(N-2).
  function automatic int unsigned win_len(input int unsigned n);
    return 32'd1 << (n - 2);
  endfunction

  localparam int unsigned L_DEF     = win_len(N_DEF);
  localparam int unsigned CNT_W_DEF = N_DEF - 2;  // counts 0..L-1
  localparam int unsigned ACC_W_DEF = N_DEF - 1;  // holds 0..L inclusive

  // ACCUM: accepting bits. HOLD: a finished window waits for the output slot.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/out_lane_acc.sv
// Per-lane ones accumulator for one stochastic bitstream.
// Latency: acc updates on the edge after en; sum is combinational (acc + bit_in).
// Backpressure: none; the controller gates en and clr.
//
// Ports: clock/reset_n (async active-low), clr (sync zero, wins over en),
// en (add bit_in this cycle), bit_in, acc (registered count), sum (acc + bit_in).
module out_lane_acc #(
  parameter int unsigned W = 7
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] acc,
  output logic [W-1:0] sum
);

  // The final-window value is taken from sum so the L-th bit is included
  // without an extra cycle.
  assign sum = acc + W'(bit_in);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/out_ctrl_sc_acc.sv
// Converts LANES unipolar stochastic bitstreams to binary ones-counts over L-bit windows.
// Latency: out_valid rises 1 cycle after the L-th accepted bit when the output slot is free.
// Backpressure: if the slot is still occupied at window end, sums park in the lane accumulators (HOLD, in_ready=0) until out_ready.
//
// Ports: clock, reset_n (async active-low), clear (sync window abort),
// in_valid/in_ready/in_bits (one bit per lane per accepted cycle),
// out_valid/out_ready/out_data (per-lane count 0..L of a finished window).
module out_ctrl_sc_acc
  import out_ctrl_sc_acc_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned LANES = LANES_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_bits,
  output logic             in_ready,
  output logic [N-2:0]     out_data [LANES],
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned L     = win_len(N);
  localparam int unsigned CNT_W = N - 2;
  localparam int unsigned ACC_W = N - 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   lane_acc [LANES];
  logic [ACC_W-1:0]   lane_sum [LANES];

  logic accept;
  logic last;
  logic slot_free;
  logic drain;
  logic lane_clr;
  logic lane_en;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign last      = accept && (cnt == CNT_W'(L - 1));
  assign slot_free = !out_valid || out_ready;
  // A parked window is released into the output register.
  assign drain     = (state == HOLD) && out_ready;

  // Accumulators restart after a completed-and-delivered window, after a
  // parked window is released, or on clear. When a window parks in HOLD the
  // final add still happens (en) and the result stays in the accumulators.
  assign lane_clr  = clear || (last && slot_free) || drain;
  assign lane_en   = accept && !clear;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    out_lane_acc #(
      .W(ACC_W)
    ) u_lane (
      .clock  (clock),
      .reset_n(reset_n),
      .clr    (lane_clr),
      .en     (lane_en),
      .bit_in (in_bits[i]),
      .acc    (lane_acc[i]),
      .sum    (lane_sum[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) out_data[i] <= '0;
    end else if (clear) begin
      // Abort the window (and any parked result); the output slot is left
      // alone apart from a normal consume.
      state <= ACCUM;
      cnt   <= '0;
      if (out_valid && out_ready) out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // cnt wraps to 0 naturally after the L-th accepted bit.
          if (accept) cnt <= cnt + CNT_W'(1);
          if (last && slot_free) begin
            for (int i = 0; i < LANES; i++) out_data[i] <= lane_sum[i];
            out_valid <= 1'b1;
          end else begin
            if (last) state <= HOLD;
            if (out_valid && out_ready) out_valid <= 1'b0;
          end
        end
        HOLD: begin
          // out_valid is necessarily 1 here; the consume and the reload
          // happen on the same edge.
          if (out_ready) begin
            for (int i = 0; i < LANES; i++) out_data[i] <= lane_acc[i];
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_out_ctrl_sc_acc.sv
// Directed self-checking bench for out_ctrl_sc_acc (N=8, LANES=4, L=64).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven per scenario.
module tb_out_ctrl_sc_acc;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_bits;
  logic       in_ready;
  logic [6:0] out_data [4];
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  out_ctrl_sc_acc #(.N(8), .LANES(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_bits  (in_bits),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  // One accepted-cycle attempt with the given bits.
  task automatic send(input logic [3:0] b);
    in_valid = 1'b1;
    in_bits  = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_bits  = 4'b1111;  // junk that must be ignored
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] pat(input int k);
    logic [3:0] b;
    b[0] = (k % 2 == 0);
    b[1] = 1'b0;
    b[2] = (k % 4 == 0);
    b[3] = 1'b1;
    return b;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bits = 4'b0; out_ready = 1'b0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data[i] !== 7'd0) begin
        n_fail++; $display("FAIL reset_out_data[%0d]: got %0d want 0", i, out_data[i]);
      end
    end
  endtask

  task automatic test_all_ones();
    out_ready = 1'b1;
    for (int k = 0; k < 63; k++) send(4'b1111);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ones_early_valid: got %b want 0", out_valid);
    end
    send(4'b1111);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL ones_valid: got %b want 1", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data[i] !== 7'd64) begin
        n_fail++; $display("FAIL ones_data[%0d]: got %0d want 64", i, out_data[i]);
      end
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ones_consume: got %b want 0", out_valid);
    end
  endtask

  task automatic test_pattern();
    int exp[4] = '{32, 0, 16, 64};
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) send(pat(k));
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL pattern_valid: got %b want 1", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data[i] !== 7'(exp[i])) begin
        n_fail++; $display("FAIL pattern_data[%0d]: got %0d want %0d", i, out_data[i], exp[i]);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    int exp1[4] = '{32, 0, 16, 64};
    int exp2[4] = '{0, 64, 0, 64};
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) send(pat(k));
    for (int k = 0; k < 64; k++) send(4'b1010);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready_hold: got %b want 0", in_ready);
    end
    idle();
    idle();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_valid_held: got %b want 1", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data[i] !== 7'(exp1[i])) begin
        n_fail++; $display("FAIL bp_first_stable[%0d]: got %0d want %0d", i, out_data[i], exp1[i]);
      end
    end
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid=%b ready=%b want 1 1", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data[i] !== 7'(exp2[i])) begin
        n_fail++; $display("FAIL bp_second[%0d]: got %0d want %0d", i, out_data[i], exp2[i]);
      end
    end
    out_ready = 1'b1;
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_gaps();
    int exp[4] = '{32, 0, 16, 64};
    out_ready = 1'b1;
    for (int k = 0; k < 63; k++) begin
      if (k % 3 == 0) idle();
      send(pat(k));
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL gaps_early_valid: got %b want 0", out_valid);
    end
    send(pat(63));
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL gaps_valid: got %b want 1", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data[i] !== 7'(exp[i])) begin
        n_fail++; $display("FAIL gaps_data[%0d]: got %0d want %0d", i, out_data[i], exp[i]);
      end
    end
    idle();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) send(4'b1111);
    clear = 1'b1;
    send(4'b1111);
    clear = 1'b0;
    for (int k = 0; k < 63; k++) send(4'b1111);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clear_early_valid: got %b want 0", out_valid);
    end
    send(4'b1111);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL clear_valid: got %b want 1", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data[i] !== 7'd64) begin
        n_fail++; $display("FAIL clear_data[%0d]: got %0d want 64", i, out_data[i]);
      end
    end
    idle();
  endtask

  task automatic test_reset_hold();
    int exp[4] = '{64, 64, 0, 0};
    out_ready = 1'b0;
    for (int k = 0; k < 128; k++) send(4'b1111);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rh_in_hold: got %b want 0", in_ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rh_async: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) send(4'b0011);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rh_valid: got %b want 1", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data[i] !== 7'(exp[i])) begin
        n_fail++; $display("FAIL rh_data[%0d]: got %0d want %0d", i, out_data[i], exp[i]);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_pattern();
    test_backpressure();
    test_gaps();
    test_clear();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
